// File: rtl/sprite_blit_scheduler.sv
// Serialises sprite blits and full-screen clears onto one ROM fetch path feeding the VGA pixel port.
// Round-robin sprite arbitration, clear has strict priority; transparency keying and screen clipping.
module sprite_blit_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SPR_W = 16,
  parameter int unsigned SPR_H = 16,
  parameter int unsigned SCR_W = 320,
  parameter int unsigned SCR_H = 240,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned COLOUR_W = 12,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 12'hF0F
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       clear_req,
  input  logic [COLOUR_W-1:0]        clear_colour,
  output logic                       clear_done,
  input  logic [N_REQ-1:0]           req,
  input  logic [9*N_REQ-1:0]         req_x,
  input  logic [8*N_REQ-1:0]         req_y,
  input  logic [ADDR_W*N_REQ-1:0]    req_base,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [COLOUR_W-1:0]        rom_q,
  output logic [8:0]                 vga_x,
  output logic [7:0]                 vga_y,
  output logic [COLOUR_W-1:0]        vga_colour,
  output logic                       vga_plot
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);
  localparam logic [9:0]       X_LIM    = 10'(SCR_W);
  localparam logic [8:0]       Y_LIM    = 9'(SCR_H);
  localparam logic [9:0]       X_LAST   = 10'(SCR_W - 1);
  localparam logic [8:0]       Y_LAST   = 9'(SCR_H - 1);

  typedef enum logic [2:0] {StIdle, StClear, StSprite, StDrain, StDone} state_e;

  state_e                r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_win;
  logic [8:0]            r_x;
  logic [7:0]            r_y;
  logic [ADDR_W-1:0]     r_rom_addr;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  // Raster counter during CLEAR; piped target coordinate during SPRITE/DRAIN.
  logic [9:0]            r_px;
  logic [8:0]            r_py;
  logic                  r_pv;
  logic [COLOUR_W-1:0]   r_clr_colour;
  logic [N_REQ-1:0]      r_grant;
  logic [N_REQ-1:0]      r_done;
  logic                  r_clear_done;

  logic                  w_any;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_cand;
  logic [8:0]            w_sel_x;
  logic [7:0]            w_sel_y;
  logic [ADDR_W-1:0]     w_sel_base;
  logic                  w_pix_stage;
  logic                  w_in_screen;

  // First requester strictly after the pointer, wrapping.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_ptr;
    w_cand = r_ptr;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = PTR_W'((32'(r_ptr) + k) % N_REQ);
      if (!w_any && req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_sel_x    = req_x[9*w_win +: 9];
  assign w_sel_y    = req_y[8*w_win +: 8];
  assign w_sel_base = req_base[ADDR_W*w_win +: ADDR_W];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_ptr        <= PTR_RST;
      r_win        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_rom_addr   <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_pv         <= 1'b0;
      r_clr_colour <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_grant      <= '0;
      r_done       <= '0;
      r_clear_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (clear_req) begin
            r_state      <= StClear;
            r_clr_colour <= clear_colour;
            r_px         <= '0;
            r_py         <= '0;
          end else if (w_any) begin
            r_state    <= StSprite;
            r_win      <= w_win;
            r_ptr      <= w_win;
            r_x        <= w_sel_x;
            r_y        <= w_sel_y;
            r_rom_addr <= w_sel_base;
            r_col      <= '0;
            r_row      <= '0;
            r_pv       <= 1'b0;
            r_grant    <= N_REQ'(1) << w_win;
          end
        end
        StClear: begin
          if (r_px == X_LAST) begin
            r_px <= '0;
            if (r_py == Y_LAST) begin
              r_py         <= '0;
              r_state      <= StDone;
              r_clear_done <= 1'b1;
            end else begin
              r_py <= r_py + 9'd1;
            end
          end else begin
            r_px <= r_px + 10'd1;
          end
        end
        StSprite: begin
          // Coordinate is widened so off-screen pixels are detected, not wrapped.
          r_px       <= {1'b0, r_x} + 10'(r_col);
          r_py       <= {1'b0, r_y} + 9'(r_row);
          r_pv       <= 1'b1;
          r_rom_addr <= r_rom_addr + ADDR_W'(1);
          if (r_col == COL_LAST) begin
            r_col <= '0;
            if (r_row == ROW_LAST) begin
              r_row   <= '0;
              r_state <= StDrain;
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
        StDrain: begin
          r_pv    <= 1'b0;
          r_state <= StDone;
          r_done  <= N_REQ'(1) << r_win;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy        = (r_state != StIdle);
  assign rom_addr    = r_rom_addr;
  assign grant       = r_grant;
  assign done        = r_done;
  assign clear_done  = r_clear_done;

  // rom_q lines up with the coordinate piped one stage behind the address.
  assign w_pix_stage = r_pv && (r_state == StSprite || r_state == StDrain);
  assign w_in_screen = (r_px < X_LIM) && (r_py < Y_LIM);
  assign vga_x       = r_px[8:0];
  assign vga_y       = r_py[7:0];
  assign vga_plot    = (r_state == StClear) ||
                       (w_pix_stage && (rom_q != TRANSPARENT) && w_in_screen);
  assign vga_colour  = (r_state == StClear) ? r_clr_colour :
                       (w_pix_stage ? rom_q : '0);

endmodule

// File: tb/tb_sprite_blit_scheduler.sv
// Bench for sprite_blit_scheduler: synchronous ROM model, per-job pixel scoreboard built from the
// sprite/clip/transparency rules, and a round-robin reference picker.
module tb_sprite_blit_scheduler;
  localparam int N_REQ = 4;
  localparam int SPR_W = 16;
  localparam int SPR_H = 16;
  localparam int SCR_W = 320;
  localparam int SCR_H = 240;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clear_req = 1'b0;
  logic [11:0]          clear_colour = '0;
  logic                 clear_done;
  logic [N_REQ-1:0]     req = '0;
  logic [9*N_REQ-1:0]   req_x;
  logic [8*N_REQ-1:0]   req_y;
  logic [16*N_REQ-1:0]  req_base;
  logic [N_REQ-1:0]     grant;
  logic [N_REQ-1:0]     done;
  logic                 busy;
  logic [15:0]          rom_addr;
  logic [11:0]          rom_q = '0;
  logic [8:0]           vga_x;
  logic [7:0]           vga_y;
  logic [11:0]          vga_colour;
  logic                 vga_plot;

  logic [8:0]  jx [N_REQ];
  logic [7:0]  jy [N_REQ];
  logic [15:0] jb [N_REQ];
  logic [11:0] rom [65536];
  logic [28:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int clr_done_cnt = 0;
  int mdl_ptr;

  sprite_blit_scheduler dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .req          (req),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_base     (req_base),
    .grant        (grant),
    .done         (done),
    .busy         (busy),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[rom_addr];

  always_comb begin
    req_x = '0;
    req_y = '0;
    req_base = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_x[9*i +: 9]     = jx[i];
      req_y[8*i +: 8]     = jy[i];
      req_base[16*i +: 16] = jb[i];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every plot must be the next pixel the reference expects.
  always @(negedge clk) begin
    if (!reset) begin
      if (vga_plot) begin
        plot_cnt++;
        check_eq("plot_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check_eq("plot_pixel", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
      end
      if (|done) done_cnt++;
      if (clear_done) clr_done_cnt++;
    end
  end

  task automatic push_sprite(input int x, input int y, input int base);
    int a, px, py;
    logic [11:0] c;
    for (int r = 0; r < SPR_H; r++) begin
      for (int k = 0; k < SPR_W; k++) begin
        a  = (base + r * SPR_W + k) % 65536;
        c  = rom[16'(a)];
        px = x + k;
        py = y + r;
        if (c != 12'hF0F && px < SCR_W && py < SCR_H) exp_q.push_back({9'(px), 8'(py), c});
      end
    end
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] m, input int p);
    for (int k = 1; k <= N_REQ; k++) if (m[2'((p + k) % N_REQ)]) return (p + k) % N_REQ;
    return -1;
  endfunction

  task automatic expect_job(input int w, input bit drop);
    int t, base;
    t = 0;
    while (grant == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("grant", grant, 64'(1) << w);
    if (grant == '0) return;
    if (drop) req = '0;
    base = int'(jb[w]);
    push_sprite(int'(jx[w]), int'(jy[w]), base);
    for (int k = 0; k < SPR_W * SPR_H; k++) begin
      check_eq("rom_addr", rom_addr, 64'((base + k) % 65536));
      if (k == 1) check_eq("grant_pulse", grant, 0);
      @(negedge clk);
    end
    t = 0;
    while (done == '0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    // Grant and done cycles are SPR_W*SPR_H+1 edges apart: the job spans 258 cycles inclusive.
    check_eq("done_latency", 64'(SPR_W * SPR_H + t), 64'(SPR_W * SPR_H + 1));
    check_eq("done", done, 64'(1) << w);
    check_eq("plots_left", 64'(exp_q.size()), 0);
  endtask

  task automatic expect_clear(input logic [11:0] c);
    int t, first, c0;
    c0 = clr_done_cnt;
    for (int y = 0; y < SCR_H; y++)
      for (int x = 0; x < SCR_W; x++) exp_q.push_back({9'(x), 8'(y), c});
    t = 0;
    while (!vga_plot && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("clear_start", vga_plot, 1);
    clear_req = 1'b0;
    first = cyc;
    t = 0;
    while (!clear_done && t < 80000) begin
      @(negedge clk);
      t++;
    end
    check_eq("clear_len", 64'(cyc - first), 64'(SCR_W * SCR_H));
    check_eq("clear_left", 64'(exp_q.size()), 0);
    @(negedge clk);
    check_eq("busy_after_clear", busy, 0);
    check_eq("clear_done_once", 64'(clr_done_cnt - c0), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p0, d0, t, w;
    logic [N_REQ-1:0] m;
    for (int n = 0; n < 65536; n++) rom[n] = 12'(n);
    for (int i = 0; i < N_REQ; i++) begin
      jx[i] = '0;
      jy[i] = '0;
      jb[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_plot", vga_plot, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_clear_done", clear_done, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_colour", vga_colour, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single sprite, ROM[n]=n
    jx[0] = 9'd16; jy[0] = 8'd16; jb[0] = 16'd0;
    p0 = plot_cnt;
    req = 4'b0001;
    expect_job(0, 1'b1);
    check_eq("single_plots", 64'(plot_cnt - p0), 256);

    // Transparency
    rom[5] = 12'hF0F;
    jx[0] = 9'd0; jy[0] = 8'd0;
    p0 = plot_cnt;
    req = 4'b0001;
    expect_job(0, 1'b1);
    check_eq("transp_plots", 64'(plot_cnt - p0), 255);
    rom[5] = 12'h005;

    // Clipping at the bottom-right corner
    jx[0] = 9'd312; jy[0] = 8'd232; jb[0] = 16'h0100;
    p0 = plot_cnt;
    req = 4'b0001;
    expect_job(0, 1'b1);
    check_eq("clip_plots", 64'(plot_cnt - p0), 64);

    // Random ROM with some transparent texels; round robin with all requests held
    do_reset();
    for (int n = 0; n < 65536; n++)
      rom[n] = ($urandom_range(0, 15) == 0) ? 12'hF0F : 12'($urandom);
    for (int i = 0; i < N_REQ; i++) begin
      jx[i] = 9'($urandom);
      jy[i] = 8'($urandom);
      jb[i] = 16'($urandom);
    end
    jb[3] = 16'hFFF8;
    req = 4'b1111;
    expect_job(0, 1'b0);
    fork
      expect_job(1, 1'b0);
      begin
        repeat (40) @(negedge clk);
        clear_colour = 12'hFFF;
        clear_req = 1'b1;
      end
    join
    expect_clear(12'hFFF);
    expect_job(2, 1'b0);
    expect_job(3, 1'b0);
    expect_job(0, 1'b1);

    // Reset mid-sprite
    jx[2] = 9'($urandom_range(0, 300));
    jy[2] = 8'($urandom_range(0, 220));
    jb[2] = 16'($urandom);
    req = 4'b0100;
    t = 0;
    while (grant == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid_grant", grant, 4'b0100);
    req = '0;
    push_sprite(int'(jx[2]), int'(jy[2]), int'(jb[2]));
    p0 = plot_cnt;
    t = 0;
    while (plot_cnt - p0 < 100 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid_100_plots", 64'(plot_cnt - p0 >= 100), 1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_plot", vga_plot, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rom_addr", rom_addr, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_no_done", 64'(done_cnt - d0), 0);
    jx[2] = 9'($urandom);
    jy[2] = 8'($urandom);
    jb[2] = 16'($urandom);
    req = 4'b0100;
    expect_job(2, 1'b1);
    mdl_ptr = 2;

    // Random request masks against the round-robin reference
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        jx[i] = 9'($urandom);
        jy[i] = 8'($urandom);
        jb[i] = 16'($urandom);
      end
      m = 4'($urandom_range(1, 15));
      w = rr_pick(m, mdl_ptr);
      req = m;
      expect_job(w, 1'b1);
      mdl_ptr = w;
    end

    repeat (4) @(negedge clk);
    check_eq("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sprite_blit_scheduler.md
Name: sprite_blit_scheduler

Overview:
- Arbitrates draw jobs from N_REQ sprite requesters plus one full-screen clear requester.
- Sequences a single sprite-ROM fetch path that drives the vga_adapter pixel port (x, y, colour, plot).
- Replaces ad-hoc per-item draw states: game logic raises a request with position and ROM base, and the scheduler serialises the jobs.
- Includes round-robin fairness, transparency keying and screen clipping.

Parameters:
N_REQ, 4, number of sprite requesters
SPR_W, 16, sprite width in pixels
SPR_H, 16, sprite height in pixels
SCR_W, 320, screen width; pixels with x>=SCR_W are not plotted
SCR_H, 240, screen height; pixels with y>=SCR_H are not plotted
ADDR_W, 16, ROM address width
COLOUR_W, 12, colour width
TRANSPARENT, 12'hF0F, ROM colour that suppresses plot

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear_req  in  1  level request: fill whole screen
clear_colour  in  COLOUR_W  fill colour, sampled at clear acceptance
clear_done  out  1  one-cycle pulse when clear finishes
req  in  N_REQ  level sprite requests, one bit per requester
req_x  in  9*N_REQ  packed sprite top-left x (requester i at [9i+8:9i])
req_y  in  8*N_REQ  packed sprite top-left y
req_base  in  ADDR_W*N_REQ  packed ROM base address of the sprite image
grant  out  N_REQ  one-hot, one-cycle pulse on acceptance
done  out  N_REQ  one-hot, one-cycle pulse when that job finishes
busy  out  1  high whenever state != IDLE
rom_addr  out  ADDR_W  synchronous ROM address; data returns next cycle
rom_q  in  COLOUR_W  ROM data
vga_x  out  9  pixel x
vga_y  out  8  pixel y
vga_colour  out  COLOUR_W  pixel colour
vga_plot  out  1  write enable for vga_adapter

Behaviour:
- Reset (async, any time, including mid-job):
  - state=IDLE.
  - All outputs 0.
  - RR pointer=N_REQ-1, so requester 0 wins first.
  - Any in-flight job is abandoned with no done pulse.
- States: IDLE, CLEAR, SPRITE, DRAIN, DONE.
- IDLE:
  - At a clock edge with clear_req=1, go to CLEAR. Clear has strict priority over sprites.
  - Otherwise, if any req bit is set, pick the first set bit after the RR pointer (wrapping). Latch that requester's x, y and base. Update the pointer to the winner. Go to SPRITE.
  - grant[winner] is high during the first SPRITE cycle only.
- Requests are level-sensitive. A requester still asserting req after its done pulse is re-queued and takes its RR turn.
- CLEAR:
  - Plots one pixel per cycle in raster order, (0,0)..(SCR_W-1,SCR_H-1), with vga_plot=1 and vga_colour=latched clear_colour.
  - After the last pixel, go to DONE. clear_done pulses in DONE.
  - Total: SCR_W*SCR_H plot cycles.
- SPRITE:
  - Each cycle issues rom_addr = base + row*SPR_W + col, with col as the inner loop.
  - row/col and the target coordinate (x+col, y+row) are piped one stage to align with rom_q.
  - After col=SPR_W-1 and row=SPR_H-1 are issued, go to DRAIN.
- Plot stage (SPRITE cycles 2..end, plus DRAIN):
  - vga_x/vga_y = piped coordinate; vga_colour = rom_q.
  - vga_plot=1 unless rom_q==TRANSPARENT, or the coordinate is >= SCR_W / SCR_H.
  - Coordinates are computed 10/9 bits wide so overflow is detected rather than wrapped.
  - vga_x/vga_y/vga_colour may hold any value while plot=0.
- DRAIN: one cycle that emits the last pixel, then DONE.
- DONE: one cycle. Pulse done[winner] or clear_done, then IDLE. New arbitration happens in IDLE on the following edge.
- Sprite job latency: SPR_W*SPR_H issue cycles + 1 drain + 1 done. Default is 258 cycles from grant to done.
- The rom_addr sum wraps modulo 2^ADDR_W; no error is flagged.
- Requests that arrive or drop mid-job are ignored until IDLE.
- A req deasserted before IDLE samples it is never granted.

Test Plan:
- Single sprite: req[0]=1, x=16, y=16, base=0, ROM[n]=n → grant[0] pulses once. 256 plots: first (16,16) colour 0, last (31,31) colour 255. rom_addr 0..255. done[0] 258 cycles after grant.
- Transparency: ROM[5]=12'hF0F, sprite at (0,0) → exactly 255 plots. No plot at (5,0).
- Clipping: sprite at x=312, y=232 → only the 8x8 pixels with x<320, y<240 are plotted (64 plots). Still 256 rom_addr issues. done on schedule.
- Round robin: req=4'b1111 held throughout → grant order 0,1,2,3,0. When clear_req is raised mid-sprite, the clear runs immediately after the current done, before the next sprite.
- Clear: clear_colour=12'hFFF → 76800 consecutive plots, (0,0) through (319,239), all 12'hFFF. clear_done pulses once. busy falls the cycle after.
- Reset mid-sprite: assert reset after 100 plots → vga_plot=0 and busy=0 immediately. No done pulse. Next req[2] is granted normally, starting at rom_addr=base.
